// File: rtl/adc_fifo_byte_packer.sv
// adc_fifo_byte_packer
// Pulls 12-bit samples from a first-word-fall-through sample FIFO and presents them to the
// register block as a byte stream: two samples become three bytes, or one byte per sample
// in low-res mode. Also keeps the read and underflow statistics reported by the register block.
//
// Handshakes:
//   sample side : samp_rd_en pops the head word; it is only raised while samp_empty=0, and
//                 samp_data is captured in the same cycle (FWFT).
//   byte side   : fifo_data is valid while fifo_empty=0; fifo_rd_en with fifo_empty=0 consumes
//                 the head byte, fifo_rd_en with fifo_empty=1 is an underflow and moves nothing.
module adc_fifo_byte_packer #(
    parameter int pCOUNT_W = 32,
    parameter int pUFLOW_W = 8
) (
    input  logic                clk_usb,
    input  logic                reset_i,
    input  logic                flush,
    input  logic                samp_empty,
    input  logic [11:0]         samp_data,
    output logic                samp_rd_en,
    input  logic                fifo_rd_en,
    output logic [7:0]          fifo_data,
    output logic                fifo_empty,
    input  logic                low_res,
    input  logic                low_res_lsb,
    input  logic                no_underflow_errors,
    input  logic                clear_fifo_errors,
    output logic [pUFLOW_W-1:0] underflow_count,
    output logic                underflow_error,
    output logic [pCOUNT_W-1:0] fifo_read_count,
    output logic [pCOUNT_W-1:0] fifo_read_count_error_freeze
);

    typedef enum logic [1:0] {
        L_A    = 2'd0,
        L_B    = 2'd1,
        L_FULL = 2'd2
    } loader_t;

    loader_t             loader_q, loader_d;
    logic [11:0]         a_q, a_d;
    logic [23:0]         stage_q, stage_d;
    logic [1:0]          stage_cnt_q, stage_cnt_d;
    logic [23:0]         out_q, out_d;
    logic [1:0]          out_cnt_q, out_cnt_d;
    logic [pCOUNT_W-1:0] read_cnt_q, read_cnt_d;
    logic [pUFLOW_W-1:0] uflow_q, uflow_d;
    logic                uerr_q, uerr_d;
    logic [pCOUNT_W-1:0] freeze_q, freeze_d;

    logic xfer;
    logic rd_ok;
    logic underflow;

    // Loader state register and datapath registers.
    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            loader_q    <= L_A;
            a_q         <= '0;
            stage_q     <= '0;
            stage_cnt_q <= '0;
            out_q       <= '0;
            out_cnt_q   <= '0;
            read_cnt_q  <= '0;
            uflow_q     <= '0;
            uerr_q      <= 1'b0;
            freeze_q    <= '0;
        end else begin
            loader_q    <= loader_d;
            a_q         <= a_d;
            stage_q     <= stage_d;
            stage_cnt_q <= stage_cnt_d;
            out_q       <= out_d;
            out_cnt_q   <= out_cnt_d;
            read_cnt_q  <= read_cnt_d;
            uflow_q     <= uflow_d;
            uerr_q      <= uerr_d;
            freeze_q    <= freeze_d;
        end
    end

    // Loader outputs: sample pop request and staging->output transfer strobe.
    always_comb begin
        samp_rd_en = !reset_i && !flush && !samp_empty &&
                     ((loader_q == L_A) || (loader_q == L_B));
        xfer       = !flush && (loader_q == L_FULL) &&
                     ((out_cnt_q == 2'd0) || ((out_cnt_q == 2'd1) && fifo_rd_en));
    end

    // Loader next state; the mode is sampled only when sample A is popped, so a pair in
    // flight (L_B) always completes as a 12-bit group.
    always_comb begin
        loader_d = loader_q;
        case (loader_q)
            L_A:     if (samp_rd_en) loader_d = low_res ? L_FULL : L_B;
            L_B:     if (samp_rd_en) loader_d = L_FULL;
            L_FULL:  if (xfer)       loader_d = L_A;
            default: loader_d = L_A;
        endcase
        if (flush) loader_d = L_A;
    end

    // Staging fill, output byte shifting, and read/underflow statistics.
    always_comb begin
        a_d         = a_q;
        stage_d     = stage_q;
        stage_cnt_d = stage_cnt_q;
        out_d       = out_q;
        out_cnt_d   = out_cnt_q;
        read_cnt_d  = read_cnt_q;
        uflow_d     = uflow_q;
        uerr_d      = uerr_q;
        freeze_d    = freeze_q;

        rd_ok     = fifo_rd_en && (out_cnt_q != 2'd0) && !flush;
        underflow = fifo_rd_en && (out_cnt_q == 2'd0) && !flush;

        if ((loader_q == L_A) && samp_rd_en) begin
            a_d = samp_data;
            if (low_res) begin
                stage_d     = {(low_res_lsb ? samp_data[7:0] : samp_data[11:4]), 16'h0000};
                stage_cnt_d = 2'd1;
            end
        end
        if ((loader_q == L_B) && samp_rd_en) begin
            // {A[11:4], {A[3:0],B[11:8]}, B[7:0]} is simply A followed by B.
            stage_d     = {a_q, samp_data};
            stage_cnt_d = 2'd3;
        end

        if (rd_ok) begin
            out_d      = out_q << 8;
            out_cnt_d  = out_cnt_q - 2'd1;
            read_cnt_d = read_cnt_q + 1'b1;
        end
        // Transfer overrides the shift: when out_cnt was 1 the last byte is being read now.
        if (xfer) begin
            out_d     = stage_q;
            out_cnt_d = stage_cnt_q;
        end
        if (flush) begin
            out_cnt_d = 2'd0;
        end

        if (underflow) begin
            if (uflow_q != {pUFLOW_W{1'b1}}) uflow_d = uflow_q + 1'b1;
            if (!no_underflow_errors && !uerr_q) begin
                uerr_d   = 1'b1;
                freeze_d = read_cnt_q;
            end
        end
        if (clear_fifo_errors) begin
            uflow_d  = '0;
            uerr_d   = 1'b0;
            freeze_d = '0;
        end
    end

    // Register-block facing outputs.
    always_comb begin
        fifo_data                    = out_q[23:16];
        fifo_empty                   = (out_cnt_q == 2'd0);
        underflow_count              = uflow_q;
        underflow_error              = uerr_q;
        fifo_read_count              = read_cnt_q;
        fifo_read_count_error_freeze = freeze_q;
    end

endmodule
